// File: rtl/pipelined_uram_pkg.sv
// rtl/pipelined_uram_pkg.sv - shared types, limits and lane-mask helper for the URAM buffer
package uram_pkg;

  typedef enum logic {URAM_IDLE = 1'b0, URAM_CLEAR = 1'b1} uram_state_t;

  localparam int MAX_READ_LATENCY = 4;
  localparam int MAX_WIDTH        = 256;

  // Expands per-lane enables into a per-bit mask; callers truncate to their WIDTH.
  function automatic logic [MAX_WIDTH-1:0] lane_mask(input logic [MAX_WIDTH-1:0] byte_en,
                                                     input int                   byte_w);
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    for (int b = 0; b < MAX_WIDTH; b++) begin
      m[b] = byte_en[b / byte_w];
    end
    return m;
  endfunction

endpackage

// File: rtl/pipelined_uram_if.sv
// rtl/pipelined_uram_if.sv - clear, write and read port bundle of the URAM buffer
interface pipelined_uram_if #(
  parameter int WIDTH      = 72,
  parameter int DEPTH_BITS = 12,
  parameter int BYTE_W     = 9
);
  localparam int NLANES = WIDTH / BYTE_W;

  logic                  clear_req;
  logic                  busy;
  logic                  access_dropped;
  logic                  write_en;
  logic [DEPTH_BITS-1:0] write_address;
  logic [NLANES-1:0]     write_byte_en;
  logic [WIDTH-1:0]      write_data_in;
  logic                  read_en;
  logic [DEPTH_BITS-1:0] read_address;
  logic                  read_valid;
  logic [WIDTH-1:0]      read_data_out;

  modport master (
    output clear_req, write_en, write_address, write_byte_en, write_data_in,
    output read_en, read_address,
    input  busy, access_dropped, read_valid, read_data_out
  );

  modport slave (
    input  clear_req, write_en, write_address, write_byte_en, write_data_in,
    input  read_en, read_address,
    output busy, access_dropped, read_valid, read_data_out
  );
endinterface

// File: rtl/pipelined_uram_read_pipe.sv
// rtl/pipelined_uram_read_pipe.sv - extra read register stages after the array output stage
module uram_read_pipe #(
  parameter int WIDTH        = 72,
  parameter int READ_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s1_valid_i,
  input  logic [WIDTH-1:0] s1_data_i,
  output logic             read_valid_o,
  output logic [WIDTH-1:0] read_data_o
);
  localparam int STAGES = READ_LATENCY - 1;

  if (STAGES == 0) begin : g_bypass
    assign read_valid_o = s1_valid_i;
    assign read_data_o  = s1_data_i;
  end else begin : g_regs
    logic [STAGES-1:0] vld_q;
    logic [WIDTH-1:0]  dat_q [STAGES];

    // Data only advances behind a valid token so the output holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int k = 0; k < STAGES; k++) dat_q[k] <= '0;
      end else begin
        vld_q[0] <= s1_valid_i;
        if (s1_valid_i) dat_q[0] <= s1_data_i;
        for (int k = 1; k < STAGES; k++) begin
          vld_q[k] <= vld_q[k-1];
          if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
        end
      end
    end

    assign read_valid_o = vld_q[STAGES-1];
    assign read_data_o  = dat_q[STAGES-1];
  end

endmodule

// File: rtl/pipelined_uram.sv
// rtl/pipelined_uram.sv - simple-dual-port URAM buffer with byte lanes, read pipeline,
// write-first collision merge and a zero-fill clear engine
module pipelined_uram
  import uram_pkg::*;
#(
  parameter int WIDTH          = 72,
  parameter int DEPTH          = 4096,
  parameter int DEPTH_BITS     = 12,
  parameter int BYTE_W         = 9,
  parameter int READ_LATENCY   = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  pipelined_uram_if.slave bus
);
  localparam int                    NLANES    = WIDTH / BYTE_W;
  localparam logic [DEPTH_BITS:0]   DEPTH_L   = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS-1:0] LAST_ADDR = DEPTH_BITS'(DEPTH - 1);

  if (WIDTH % BYTE_W != 0) begin : g_err_width
    $error("pipelined_uram: WIDTH must be a multiple of BYTE_W");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_err_lat
    $error("pipelined_uram: READ_LATENCY must be within 1..4");
  end
  if (DEPTH > 2**DEPTH_BITS) begin : g_err_depth
    $error("pipelined_uram: DEPTH exceeds 2**DEPTH_BITS");
  end

  uram_state_t           state_q, state_d;
  logic [DEPTH_BITS-1:0] clr_addr_q, clr_addr_d;
  logic                  clear_pending_q;
  logic                  dropped_q;
  logic                  s1_valid_q;
  logic [WIDTH-1:0]      s1_data_q, s1_data_d;

  logic                  user_ok, wr_hit, rd_ok, rd_in_range, collide;
  logic                  mem_we;
  logic [DEPTH_BITS-1:0] mem_waddr;
  logic [NLANES-1:0]     mem_wbe;
  logic [WIDTH-1:0]      mem_wdata, wr_mask, rd_word;

  (* ram_style = "ultra" *) logic [WIDTH-1:0] mem_q [DEPTH];

  assign user_ok     = (state_q == URAM_IDLE);
  assign wr_hit      = user_ok && bus.write_en && (|bus.write_byte_en)
                       && ({1'b0, bus.write_address} < DEPTH_L);
  assign rd_ok       = user_ok && bus.read_en;
  assign rd_in_range = ({1'b0, bus.read_address} < DEPTH_L);
  assign collide     = wr_hit && (bus.write_address == bus.read_address);
  assign wr_mask     = WIDTH'(lane_mask(MAX_WIDTH'(bus.write_byte_en), BYTE_W));
  assign rd_word     = mem_q[bus.read_address];

  always_comb begin
    s1_data_d = '0;
    if (rd_in_range) begin
      s1_data_d = collide ? ((rd_word & ~wr_mask) | (bus.write_data_in & wr_mask)) : rd_word;
    end
  end

  // The clear engine owns the write port for the whole CLEAR state.
  always_comb begin
    mem_we    = wr_hit;
    mem_waddr = bus.write_address;
    mem_wbe   = bus.write_byte_en;
    mem_wdata = bus.write_data_in;
    if (state_q == URAM_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr_q;
      mem_wbe   = '1;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NLANES; i++) begin
        if (mem_wbe[i]) mem_q[mem_waddr][i*BYTE_W +: BYTE_W] <= mem_wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      URAM_IDLE: begin
        if (clear_pending_q || bus.clear_req) begin
          state_d    = URAM_CLEAR;
          clr_addr_d = '0;
        end
      end
      URAM_CLEAR: begin
        if (clr_addr_q == LAST_ADDR) state_d = URAM_IDLE;
        else                         clr_addr_d = clr_addr_q + DEPTH_BITS'(1);
      end
      default: state_d = URAM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= URAM_IDLE;
      clr_addr_q      <= '0;
      clear_pending_q <= (CLEAR_ON_RESET != 0);
      dropped_q       <= 1'b0;
      s1_valid_q      <= 1'b0;
      s1_data_q       <= '0;
    end else begin
      state_q         <= state_d;
      clr_addr_q      <= clr_addr_d;
      clear_pending_q <= 1'b0;
      dropped_q       <= (state_q == URAM_CLEAR) && (bus.read_en || bus.write_en);
      s1_valid_q      <= rd_ok;
      if (rd_ok) s1_data_q <= s1_data_d;
    end
  end

  assign bus.busy           = (state_q == URAM_CLEAR);
  assign bus.access_dropped = dropped_q;

  uram_read_pipe #(
    .WIDTH        (WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_read_pipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .s1_valid_i   (s1_valid_q),
    .s1_data_i    (s1_data_q),
    .read_valid_o (bus.read_valid),
    .read_data_o  (bus.read_data_out)
  );

endmodule

// File: tb/tb_pipelined_uram.sv
// tb/tb_pipelined_uram.sv - scoreboard bench for pipelined_uram at read latencies 1, 2 and 4
module tb_pipelined_uram;
  localparam int W  = 72;
  localparam int D  = 16;
  localparam int AB = 5;
  localparam int BW = 9;
  localparam int NL = 8;

  typedef struct {
    logic [W-1:0] d;
    int           c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  logic          clear_req = 1'b0, write_en = 1'b0, read_en = 1'b0;
  logic [AB-1:0] write_address = '0, read_address = '0;
  logic [NL-1:0] write_byte_en = '0;
  logic [W-1:0]  write_data_in = '0;

  logic          rv[3], bz[3], dr[3];
  logic [W-1:0]  rd[3];

  exp_t          q[3][$];
  logic [W-1:0]  mem_m [D];
  int            clr_lo = 1, clr_hi = 0;
  bit            exp_drop[int];
  int            n_vec = 0, n_bad = 0;
  bit            fin_req = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
    pipelined_uram_if #(.WIDTH(W), .DEPTH_BITS(AB), .BYTE_W(BW)) bus ();
    assign bus.clear_req     = clear_req;
    assign bus.write_en      = write_en;
    assign bus.write_address = write_address;
    assign bus.write_byte_en = write_byte_en;
    assign bus.write_data_in = write_data_in;
    assign bus.read_en       = read_en;
    assign bus.read_address  = read_address;
    assign rv[gi] = bus.read_valid;
    assign rd[gi] = bus.read_data_out;
    assign bz[gi] = bus.busy;
    assign dr[gi] = bus.access_dropped;
    pipelined_uram #(
      .WIDTH(W), .DEPTH(D), .DEPTH_BITS(AB), .BYTE_W(BW),
      .READ_LATENCY(L), .CLEAR_ON_RESET(1)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );
  end

  function automatic int lat(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
  endfunction

  function automatic logic [W-1:0] rnd();
    return W'({$urandom(), $urandom(), $urandom()});
  endfunction

  // One cycle of stimulus; the model applies writes before reads (write-first).
  task automatic step(input bit clr, input bit we, input int wa, input logic [NL-1:0] be,
                      input logic [W-1:0] wd, input bit re, input int ra);
    bit   bsy;
    exp_t e;
    @(negedge clk);
    clear_req     = clr;
    write_en      = we;
    write_address = AB'(wa);
    write_byte_en = be;
    write_data_in = wd;
    read_en       = re;
    read_address  = AB'(ra);
    bsy = (cyc >= clr_lo) && (cyc <= clr_hi);
    if (bsy) begin
      if (we || re) exp_drop[cyc+1] = 1'b1;
    end else begin
      if (we && wa < D)
        for (int l = 0; l < NL; l++)
          if (be[l]) mem_m[wa][l*BW +: BW] = wd[l*BW +: BW];
      if (re) begin
        e.d = (ra < D) ? mem_m[ra] : '0;
        for (int i = 0; i < 3; i++) begin
          e.c = cyc + lat(i);
          q[i].push_back(e);
        end
      end
      if (clr) begin
        for (int a = 0; a < D; a++) mem_m[a] = '0;
        clr_lo = cyc + 1;
        clr_hi = cyc + D;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 0, '0, '0, 1'b0, 0);
  endtask

  task automatic release_rst();
    rst_n = 1'b1;
    for (int a = 0; a < D; a++) mem_m[a] = '0;
    clr_lo = cyc + 1;
    clr_hi = cyc + D;
  endtask

  task automatic async_reset(input int hold);
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    clear_req = 1'b0; write_en = 1'b0; read_en = 1'b0;
    clr_lo    = 1;
    clr_hi    = 0;
    exp_drop.delete();
    repeat (hold) @(negedge clk);
    release_rst();
  endtask

  initial begin : monitor
    exp_t e;
    bit   eb, ed;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        eb = rst_n && (cyc >= clr_lo) && (cyc <= clr_hi);
        ed = rst_n && exp_drop.exists(cyc);
        n_vec++;
        if (bz[i] !== eb) begin
          n_bad++;
          $display("FAIL busy lat%0d cyc %0d: got %b want %b", lat(i), cyc, bz[i], eb);
        end
        n_vec++;
        if (dr[i] !== ed) begin
          n_bad++;
          $display("FAIL access_dropped lat%0d cyc %0d: got %b want %b", lat(i), cyc, dr[i], ed);
        end
        if (!rst_n) begin
          q[i].delete();
          n_vec++;
          if (rv[i] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid lat%0d cyc %0d: got %b want 0", lat(i), cyc, rv[i]);
          end
        end else begin
          while (q[i].size() > 0 && q[i][0].c < cyc) begin
            e = q[i].pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL missing_valid lat%0d cyc %0d: got none want data %h at cyc %0d",
                     lat(i), cyc, e.d, e.c);
          end
          if (rv[i] === 1'b1) begin
            n_vec++;
            if (q[i].size() == 0) begin
              n_bad++;
              $display("FAIL spurious_valid lat%0d cyc %0d: got data %h want no valid", lat(i), cyc, rd[i]);
            end else begin
              e = q[i].pop_front();
              if (e.c != cyc || rd[i] !== e.d) begin
                n_bad++;
                $display("FAIL read lat%0d cyc %0d: got %h want %h at cyc %0d", lat(i), cyc, rd[i], e.d, e.c);
              end
            end
          end else if (rv[i] !== 1'b0) begin
            n_vec++;
            n_bad++;
            $display("FAIL read_valid_x lat%0d cyc %0d: got %b want 0/1", lat(i), cyc, rv[i]);
          end
          if (fin_req) begin
            n_vec++;
            if (q[i].size() != 0) begin
              n_bad++;
              $display("FAIL pending_reads lat%0d: got %0d outstanding want 0", lat(i), q[i].size());
              q[i].delete();
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end

  initial begin : stimulus
    logic [W-1:0] dv;
    repeat (3) @(negedge clk);
    release_rst();
    idle(18);

    for (int a = 0; a < D; a++) step(1'b0, 1'b0, 0, '0, '0, 1'b1, a);

    step(1'b0, 1'b1, 5, 8'hFF, {9{8'hAB}}, 1'b0, 0);
    step(1'b0, 1'b1, 5, 8'h01, '0, 1'b0, 0);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, 5);

    step(1'b0, 1'b1, 3, 8'hFF, rnd(), 1'b1, 3);
    step(1'b0, 1'b1, 3, 8'h04, rnd(), 1'b1, 3);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, 3);

    for (int a = 0; a < 8; a++) step(1'b0, 1'b1, a, 8'hFF, rnd(), 1'b0, 0);
    for (int a = 0; a < 8; a++) step(1'b0, 1'b0, 0, '0, '0, 1'b1, a);

    step(1'b0, 1'b1, 20, 8'hFF, rnd(), 1'b1, 20);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, 17);
    step(1'b0, 1'b1, 16, 8'hFF, rnd(), 1'b1, 4);

    dv = rnd();
    step(1'b0, 1'b1, 2, 8'hFF, dv, 1'b0, 0);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, 2);
    step(1'b1, 1'b0, 0, '0, '0, 1'b0, 0);
    step(1'b0, 1'b1, 0, 8'hFF, rnd(), 1'b0, 0);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, 9);
    idle(4);
    step(1'b1, 1'b0, 0, '0, '0, 1'b0, 0);
    idle(3);
    step(1'b0, 1'b1, 0, 8'hFF, rnd(), 1'b0, 0);
    idle(12);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, 0);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, 2);

    for (int n = 0; n < 200; n++) begin
      int wa, ra;
      wa = $urandom_range(0, 19);
      ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 19);
      step(($urandom_range(0, 79) == 0), $urandom_range(0, 1) == 1, wa, NL'($urandom()),
           rnd(), $urandom_range(0, 1) == 1, ra);
    end
    idle(18);

    for (int a = 0; a < D; a++) step(1'b0, 1'b1, a, 8'hFF, rnd() | 72'h1, 1'b0, 0);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, 13);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, 14);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, 15);
    step(1'b1, 1'b0, 0, '0, '0, 1'b0, 0);
    idle(1);
    async_reset(2);
    idle(18);
    for (int a = 0; a < D; a++) step(1'b0, 1'b0, 0, '0, '0, 1'b1, a);
    idle(6);

    fin_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
